// File: rtl/uart_tx_port_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_port_if
// Description : CPU-side bus and serial-line bundle for uart_tx_port.
//               master = CPU / bench side, slave = UART port side.
//   address  [15:0]  CPU bus address
//   write_en         CPU write strobe
//   data_in  [7:0]   CPU write data
//   data_out [7:0]   status read data (combinational)
//   sel              address decode hit (combinational)
//   tx               serial output, idle high
//   tx_busy          transmitter not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_port_if;
    logic [15:0] address;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        sel;
    logic        tx;
    logic        tx_busy;

    modport master (
        output address, write_en, data_in,
        input  data_out, sel, tx, tx_busy
    );

    modport slave (
        input  address, write_en, data_in,
        output data_out, sel, tx, tx_busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_port
// Description : Memory-mapped 8N1 UART transmitter with a small write FIFO.
//               Data register at BASE_ADDR (write pushes a byte), status
//               register at BASE_ADDR+1 (read {4'b0,overflow,busy,empty,full},
//               any write clears overflow).
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   bus          uart_tx_port_if.slave (address/write_en/data_in in,
//                data_out/sel/tx/tx_busy out)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_port #(
    parameter logic [15:0] BASE_ADDR    = 16'hf010,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_AW      = 2
) (
    input wire              clock,
    input wire              reset,
    uart_tx_port_if.slave   bus
);

    localparam int              c_DEPTH     = 2 ** FIFO_AW;
    localparam logic [15:0]     c_STAT_ADDR = BASE_ADDR + 16'd1;
    // A 1-bit counter is kept even when CLKS_PER_BIT=1; it simply never moves.
    localparam int              c_BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]    c_FULL_CNT  = (FIFO_AW + 1)'(c_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [7:0]         fifo_mem_q [c_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    state_t             state_q;
    logic               tx_q;
    logic               tx_busy_q;
    logic [7:0]         shift_q;
    logic [c_BAUD_W-1:0] baud_q;
    logic [2:0]         bit_idx_q;

    // ------------------------------------------------------------------
    // Decode and FIFO control
    // ------------------------------------------------------------------
    logic w_empty, w_full, w_pop, w_push_req, w_push, w_ovf_evt, w_stat_wr, w_baud_done;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == c_FULL_CNT);
    // The FSM drains the FIFO whenever it is idle; this is the only pop source.
    assign w_pop      = (state_q == S_IDLE) && !w_empty;
    assign w_push_req = bus.write_en && (bus.address == BASE_ADDR);
    // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_ovf_evt  = w_push_req && w_full && !w_pop;
    assign w_stat_wr  = bus.write_en && (bus.address == c_STAT_ADDR);
    assign w_baud_done = (baud_q == c_BAUD_LAST);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Setting wins over a same-edge clear.
        if (w_ovf_evt) begin
            overflow_d = 1'b1;
        end else if (w_stat_wr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Data array needs no reset: the pointers/count define what is valid.
    always_ff @(posedge clock) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM; tx and tx_busy are registered alongside the state.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_q      <= 1'b1;
            tx_busy_q <= 1'b0;
            shift_q   <= '0;
            baud_q    <= '0;
            bit_idx_q <= '0;
            rd_ptr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (w_pop) begin
                        shift_q   <= fifo_mem_q[rd_ptr_q];
                        rd_ptr_q  <= rd_ptr_q + 1'b1;
                        baud_q    <= '0;
                        state_q   <= S_START;
                        tx_q      <= 1'b0;
                        tx_busy_q <= 1'b1;
                    end else begin
                        tx_busy_q <= 1'b0;
                    end
                end

                S_START: begin
                    if (w_baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= S_DATA;
                        tx_q      <= shift_q[0];
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_baud_done) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= S_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            // Next bit is the one about to land in shift_q[0].
                            tx_q      <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                S_STOP: begin
                    if (w_baud_done) begin
                        baud_q    <= '0;
                        state_q   <= S_IDLE;
                        tx_q      <= 1'b1;
                        tx_busy_q <= 1'b0;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end

                default: begin
                    state_q   <= S_IDLE;
                    tx_q      <= 1'b1;
                    tx_busy_q <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.tx      = tx_q;
    assign bus.tx_busy = tx_busy_q;
    assign bus.sel     = (bus.address == BASE_ADDR) || (bus.address == c_STAT_ADDR);
    assign bus.data_out = (!bus.write_en && (bus.address == c_STAT_ADDR))
                        ? {4'b0000, overflow_q, tx_busy_q, w_empty, w_full}
                        : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_port
// Description : Self-checking bench for uart_tx_port (CLKS_PER_BIT=4,
//               depth 4). Table of bus decode/read vectors plus directed
//               frame, FIFO overflow, full-with-pop and async reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_port;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    uart_tx_port_if bus ();

    uart_tx_port #(
        .BASE_ADDR    (16'hf010),
        .CLKS_PER_BIT (4),
        .FIFO_AW      (2)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [7:0]  din;
        logic        exp_sel;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic read_status(input string nm, input logic [7:0] exp);
        bus.address  = 16'hf011;
        bus.write_en = 1'b0;
        #1;
        chk(nm, bus.data_out, exp);
    endtask

    task automatic write_byte(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address  = a;
        bus.write_en = 1'b1;
        bus.data_in  = d;
        @(negedge clk);
        bus.write_en = 1'b0;
        bus.address  = 16'h0000;
        bus.data_in  = 8'h00;
    endtask

    // Called at the negedge j0 cycles after the start bit began; samples the
    // second cycle of each bit and returns at the negedge 40 cycles in.
    task automatic check_frame(input logic [7:0] d, input int j0);
        logic exp_bit;
        for (int j = j0; j < 40; j++) begin
            if (j % 4 == 1) begin
                if (j / 4 == 0)      exp_bit = 1'b0;
                else if (j / 4 == 9) exp_bit = 1'b1;
                else                 exp_bit = d[j / 4 - 1];
                chk($sformatf("frame_%02h_bit%0d", d, j / 4), {7'd0, bus.tx}, {7'd0, exp_bit});
            end
            @(negedge clk);
        end
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_tx"}, {7'd0, bus.tx}, 8'd1);
        chk({nm, "_busy"}, {7'd0, bus.tx_busy}, 8'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{16'hf011, 1'b0, 8'h00, 1'b1, 8'h02};
        vecs[1] = '{16'hf010, 1'b0, 8'h00, 1'b1, 8'h00};
        vecs[2] = '{16'hf012, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[3] = '{16'hf00f, 1'b0, 8'h00, 1'b0, 8'h00};
        vecs[4] = '{16'hf011, 1'b1, 8'h5a, 1'b1, 8'h00};
        vecs[5] = '{16'h1234, 1'b1, 8'h41, 1'b0, 8'h00};
        vecs[6] = '{16'h0000, 1'b0, 8'h00, 1'b0, 8'h00};

        rst          = 1'b1;
        bus.address  = 16'h0000;
        bus.write_en = 1'b0;
        bus.data_in  = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Quiet after reset.
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            read_status("reset_status", 8'h02);
            chk("reset_tx", {7'd0, bus.tx}, 8'd1);
            chk("reset_busy", {7'd0, bus.tx_busy}, 8'd0);
        end

        // Decode / read-path table.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.address  = vecs[i].addr;
            bus.write_en = vecs[i].we;
            bus.data_in  = vecs[i].din;
            #1;
            chk($sformatf("vec%0d_sel", i), {7'd0, bus.sel}, {7'd0, vecs[i].exp_sel});
            chk($sformatf("vec%0d_dout", i), bus.data_out, vecs[i].exp_dout);
        end
        @(negedge clk);
        bus.write_en = 1'b0;
        repeat (5) @(negedge clk);
        check_idle("no_frame_other_addr");
        read_status("status_after_table", 8'h02);

        // Single byte 8'h41.
        write_byte(16'hf010, 8'h41);
        @(negedge clk);
        check_frame(8'h41, 0);
        check_idle("after_41");

        // Back-to-back 8'h55, 8'hAA.
        @(negedge clk);
        bus.address = 16'hf010; bus.write_en = 1'b1; bus.data_in = 8'h55;
        @(negedge clk);
        bus.data_in = 8'haa;
        @(negedge clk);
        bus.write_en = 1'b0; bus.address = 16'h0000;
        check_frame(8'h55, 0);
        check_idle("gap_55_aa");
        @(negedge clk);
        check_frame(8'haa, 0);
        check_idle("after_aa");
        read_status("status_after_aa", 8'h02);

        // Six bytes into a depth-4 FIFO: 06 is dropped.
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            bus.address = 16'hf010; bus.write_en = 1'b1; bus.data_in = 8'(i);
        end
        @(negedge clk);
        bus.write_en = 1'b0;
        read_status("status_overflow_full", 8'h0d);
        check_frame(8'h01, 4);
        check_idle("after_01");
        for (int b = 2; b <= 5; b++) begin
            @(negedge clk);
            check_frame(8'(b), 0);
            check_idle($sformatf("after_%02h", b));
        end
        read_status("status_ovf_drained", 8'h0a);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("no_sixth_frame", {7'd0, bus.tx}, 8'd1);
        end
        write_byte(16'hf011, 8'h00);
        read_status("status_ovf_cleared", 8'h02);

        // Full FIFO in IDLE: a push on the pop edge is accepted, no overflow.
        @(negedge clk);
        bus.address = 16'hf010; bus.write_en = 1'b1; bus.data_in = 8'ha0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.data_in = 8'hb0 + 8'(i);
        end
        @(negedge clk);
        bus.write_en = 1'b0;
        read_status("status_full_busy", 8'h05);
        check_frame(8'ha0, 3);
        check_idle("idle_full");
        read_status("status_full_idle", 8'h01);
        bus.address = 16'hf010; bus.write_en = 1'b1; bus.data_in = 8'hc5;
        @(negedge clk);
        bus.write_en = 1'b0;
        read_status("status_push_on_pop", 8'h05);
        check_frame(8'hb1, 0);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check_frame(8'hb0 + 8'(i), 0);
        end
        @(negedge clk);
        check_frame(8'hc5, 0);
        check_idle("after_c5");
        read_status("status_after_c5", 8'h02);

        // Asynchronous reset during data bit 3.
        @(negedge clk);
        bus.address = 16'hf010; bus.write_en = 1'b1; bus.data_in = 8'h37;
        @(negedge clk);
        bus.data_in = 8'h38;
        @(negedge clk);
        bus.data_in = 8'h39;
        @(negedge clk);
        bus.write_en = 1'b0;
        repeat (16) @(negedge clk);
        chk("bit3_before_reset", {7'd0, bus.tx}, 8'd0);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_tx", {7'd0, bus.tx}, 8'd1);
        chk("async_reset_busy", {7'd0, bus.tx_busy}, 8'd0);
        read_status("async_reset_status", 8'h02);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("no_frame_after_reset", {7'd0, bus.tx}, 8'd1);
        end
        read_status("status_end", 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
